i2c_reg_access: RTL and testbench

I2C_REG_ACCESS -- requirements
Module: i2c_reg_access

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_sync.sv | 34 +++
 rtl/i2c_reg_access.sv | 185 ++++++++++++++++++
 tb/tb_i2c_reg_access.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C register-access controller.
//   state_t        - controller FSM states
//   MAX_WR_LEN     - largest legal req_len for a register write
//   BITS_PER_BYTE  - SCL rises per byte on the wire (8 data + ACK)
//   expected_rises - SCL rises a complete phase of a given m_size produces
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_GO,
        WR_RUN,
        RD_GO,
        RD_RUN,
        DONE
    } state_t;

    localparam int unsigned MAX_WR_LEN    = 2;
    localparam int unsigned BITS_PER_BYTE = 9;

    function automatic logic [5:0] expected_rises(input logic [1:0] size);
        return 6'(BITS_PER_BYTE * (32'(size) + 32'd2));
    endfunction

endpackage

// File: rtl/i2c_sync.sv
// i2c_sync: 2-FF synchronizer with edge pulses.
//   clk, rst - clock, async active-high reset
//   d        - asynchronous input
//   q        - synchronized level
//   rise     - one-cycle pulse on synchronized 0->1
//   fall     - one-cycle pulse on synchronized 1->0
module i2c_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
            prev <= '0;
        end else begin
            meta <= d;
            q    <= meta;
            prev <= q;
        end
    end

    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/i2c_reg_access.sv
// i2c_reg_access: sequences register writes/reads through an I2C byte master.
//   clk, rst                       - clock, async active-high reset
//   req_valid/req_ready            - request handshake (ready only in IDLE)
//   req_write, req_dev, req_reg,
//   req_len, req_wdata             - request fields (len = data bytes - 1)
//   resp_valid, resp_err,
//   resp_rdata                     - completion pulse, error flag, read data
//   m_start, m_read_nwrite, m_addr,
//   m_size, m_data_i, m_data_valid - master control
//   m_busy, m_newData, m_data_o,
//   scl_i                          - master status/read data, monitored SCL
module i2c_reg_access
    import i2c_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [6:0]  req_dev,
    input  logic [7:0]  req_reg,
    input  logic [1:0]  req_len,
    input  logic [23:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        m_start,
    output logic        m_read_nwrite,
    output logic [6:0]  m_addr,
    output logic [1:0]  m_size,
    output logic [7:0]  m_data_i,
    output logic        m_data_valid,
    input  logic        m_busy,
    input  logic        m_newData,
    input  logic [7:0]  m_data_o,
    input  logic        scl_i
);

    state_t      state, state_nx;
    logic        err_set;

    logic        wr_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_q;
    logic [1:0]  len_q;
    logic [23:0] wdata_q;

    logic [5:0]  rise_cnt;
    logic [3:0]  bitcnt;
    logic [2:0]  bytecnt;
    logic [1:0]  rdidx;
    logic [1:0]  size_c;
    logic        phase_ok;
    logic        active;

    logic busy_s, busy_rise, busy_fall;
    logic scl_s, scl_rise, scl_fall;
    logic nd_s, nd_rise, nd_fall;
    logic sync_unused;

    i2c_sync u_sync_busy (.clk(clk), .rst(rst), .d(m_busy),
                          .q(busy_s), .rise(busy_rise), .fall(busy_fall));
    i2c_sync u_sync_scl  (.clk(clk), .rst(rst), .d(scl_i),
                          .q(scl_s), .rise(scl_rise), .fall(scl_fall));
    i2c_sync u_sync_nd   (.clk(clk), .rst(rst), .d(m_newData),
                          .q(nd_s), .rise(nd_rise), .fall(nd_fall));

    assign sync_unused = ^{busy_rise, scl_s, scl_fall, nd_s, nd_rise};

    // Write phase carries the data bytes (pointer only for a read);
    // read phase size comes straight from the request.
    always_comb begin
        if (state == RD_GO || state == RD_RUN) size_c = len_q;
        else if (wr_q)                         size_c = len_q + 2'd1;
        else                                   size_c = '0;
    end

    assign phase_ok = (rise_cnt == expected_rises(size_c));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        err_set  = 1'b0;
        unique case (state)
            IDLE: if (req_valid) begin
                if (req_write && (32'(req_len) > MAX_WR_LEN)) begin
                    state_nx = DONE;
                    err_set  = 1'b1;
                end else begin
                    state_nx = WR_GO;
                end
            end
            WR_GO:  if (busy_s) state_nx = WR_RUN;
            WR_RUN: if (busy_fall) begin
                if (phase_ok) state_nx = wr_q ? DONE : RD_GO;
                else begin
                    state_nx = DONE;
                    err_set  = 1'b1;
                end
            end
            RD_GO:  if (busy_s) state_nx = RD_RUN;
            RD_RUN: if (busy_fall) begin
                state_nx = DONE;
                err_set  = ~phase_ok;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        active        = (state == WR_GO) || (state == WR_RUN) ||
                        (state == RD_GO) || (state == RD_RUN);
        req_ready     = (state == IDLE);
        resp_valid    = (state == DONE);
        m_start       = (state == WR_GO) || (state == RD_GO);
        m_data_valid  = (state == WR_GO) || (state == WR_RUN);
        m_read_nwrite = (state == RD_GO) || (state == RD_RUN);
        m_addr        = active ? dev_q  : '0;
        m_size        = active ? size_c : '0;
        unique case (bytecnt)
            3'd0:    m_data_i = reg_q;
            3'd1:    m_data_i = wdata_q[7:0];
            3'd2:    m_data_i = wdata_q[15:8];
            3'd3:    m_data_i = wdata_q[23:16];
            default: m_data_i = '0;
        endcase
    end

    // Request latch, bit/byte tracking and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q       <= '0;
            dev_q      <= '0;
            reg_q      <= '0;
            len_q      <= '0;
            wdata_q    <= '0;
            rise_cnt   <= '0;
            bitcnt     <= '0;
            bytecnt    <= '0;
            rdidx      <= '0;
            resp_err   <= '0;
            resp_rdata <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                wr_q       <= req_write;
                dev_q      <= req_dev;
                reg_q      <= req_reg;
                len_q      <= req_len;
                wdata_q    <= req_wdata;
                resp_err   <= '0;
                resp_rdata <= '0;
            end
            if (err_set) resp_err <= 1'b1;

            if (state == WR_GO || state == RD_GO) begin
                rise_cnt <= '0;
                bitcnt   <= '0;
                bytecnt  <= '0;
                rdidx    <= '0;
            end else if ((state == WR_RUN || state == RD_RUN) && scl_rise) begin
                rise_cnt <= rise_cnt + 6'd1;
                if (bitcnt == 4'(BITS_PER_BYTE)) begin
                    bitcnt  <= 4'd1;
                    bytecnt <= bytecnt + 3'd1;
                end else begin
                    bitcnt  <= bitcnt + 4'd1;
                end
            end

            if (state == RD_RUN && nd_fall) begin
                resp_rdata[{rdidx, 3'b000} +: 8] <= m_data_o;
                rdidx                            <= rdidx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_access.sv
// tb_i2c_reg_access: directed self-checking bench; the bench plays the byte
// master and slave, clocking SCL rises and returning read bytes.
module tb_i2c_reg_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [6:0]  req_dev;
    logic [7:0]  req_reg;
    logic [1:0]  req_len;
    logic [23:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        m_start;
    logic        m_read_nwrite;
    logic [6:0]  m_addr;
    logic [1:0]  m_size;
    logic [7:0]  m_data_i;
    logic        m_data_valid;
    logic        m_busy;
    logic        m_newData;
    logic [7:0]  m_data_o;
    logic        scl_i;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    logic [7:0]  cap [0:4];
    logic [1:0]  size_start, size_end;
    logic [6:0]  addr_end;
    logic        dv_start;
    logic        r_got, r_err;
    logic [31:0] r_data;

    i2c_reg_access dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_dev(req_dev), .req_reg(req_reg), .req_len(req_len),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .m_start(m_start), .m_read_nwrite(m_read_nwrite), .m_addr(m_addr),
        .m_size(m_size), .m_data_i(m_data_i), .m_data_valid(m_data_valid),
        .m_busy(m_busy), .m_newData(m_newData), .m_data_o(m_data_o),
        .scl_i(scl_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [1:0] len, input logic [23:0] wd);
        @(negedge clk);
        check("ready_before_req", 32'(req_ready), 1);
        req_write = wr; req_dev = dev; req_reg = rg; req_len = len; req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Plays one bus phase: start handshake, nbits SCL rises, captures the
    // next outgoing byte at each byte boundary, returns read bytes.
    task automatic run_phase(input int unsigned nbits, input logic is_rd,
                             input logic [31:0] rd, input logic release_busy);
        logic seen;
        int unsigned b;
        seen = 1'b0;
        for (int unsigned i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_start) begin seen = 1'b1; break; end
        end
        check("start_seen", 32'(seen), 1);
        m_busy = 1'b1;
        seen = 1'b0;
        for (int unsigned i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!m_start) begin seen = 1'b1; break; end
        end
        check("start_dropped", 32'(seen), 1);
        cap[0]     = {m_addr, m_read_nwrite};
        size_start = m_size;
        dv_start   = m_data_valid;
        for (int unsigned i = 0; i < nbits; i++) begin
            scl_i = 1'b1; repeat (4) @(negedge clk);
            scl_i = 1'b0; repeat (4) @(negedge clk);
            if (i % 9 == 8) begin
                b = i / 9;
                if (!is_rd && b + 1 < 5) cap[b + 1] = m_data_i;
                if (is_rd && b >= 1) begin
                    m_data_o  = rd[8 * (b - 1) +: 8];
                    m_newData = 1'b1; repeat (4) @(negedge clk);
                    m_newData = 1'b0; repeat (4) @(negedge clk);
                end
            end
        end
        size_end = m_size;
        addr_end = m_addr;
        if (release_busy) begin
            m_busy = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_resp();
        r_got = 1'b0; r_err = 1'b0; r_data = '0;
        for (int unsigned i = 0; i < 300; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                r_got = 1'b1; r_err = resp_err; r_data = resp_rdata;
                break;
            end
        end
        check("resp_seen", 32'(r_got), 1);
    endtask

    initial begin
        int unsigned cnt, lat;
        logic seen, ill_err;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_dev = '0; req_reg = '0;
        req_len = '0; req_wdata = '0; m_busy = 1'b0; m_newData = 1'b0;
        m_data_o = '0; scl_i = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ready",   32'(req_ready), 1);
        check("rst_start",   32'(m_start), 0);
        check("rst_dv",      32'(m_data_valid), 0);
        check("rst_rvalid",  32'(resp_valid), 0);
        check("rst_rerr",    32'(resp_err), 0);
        check("rst_rdata",   resp_rdata, 0);
        check("rst_addr",    32'(m_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        // Write dev 0x48 reg 0x01 len 1 data 0xBEEF, with an ignored request
        issue(1'b1, 7'h48, 8'h01, 2'd1, 24'h00BEEF);
        check("wr_ready_busy", 32'(req_ready), 0);
        req_write = 1'b1; req_len = 2'd3; req_dev = 7'h11;
        req_valid = 1'b1; repeat (2) @(negedge clk); req_valid = 1'b0;
        run_phase(36, 1'b0, 32'h0, 1'b1);
        check("wr_byte0", 32'(cap[0]), 32'h90);
        check("wr_byte1", 32'(cap[1]), 32'h01);
        check("wr_byte2", 32'(cap[2]), 32'hEF);
        check("wr_byte3", 32'(cap[3]), 32'hBE);
        check("wr_size_start", 32'(size_start), 2);
        check("wr_size_end",   32'(size_end), 2);
        check("wr_addr_end",   32'(addr_end), 32'h48);
        check("wr_dv",         32'(dv_start), 1);
        wait_resp();
        check("wr_err", 32'(r_err), 0);
        cnt = 0;
        for (int unsigned i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid || m_start) cnt++;
        end
        check("ignored_req_no_resp", cnt, 0);

        // Read dev 0x48 reg 0x00 len 1, slave returns 0x12,0x34
        issue(1'b0, 7'h48, 8'h00, 2'd1, 24'h0);
        run_phase(18, 1'b0, 32'h0, 1'b1);
        check("rd_ptr_byte0", 32'(cap[0]), 32'h90);
        check("rd_ptr_byte1", 32'(cap[1]), 32'h00);
        check("rd_ptr_size",  32'(size_start), 0);
        run_phase(27, 1'b1, 32'h0000_3412, 1'b1);
        check("rd_byte0",     32'(cap[0]), 32'h91);
        check("rd_size_start", 32'(size_start), 1);
        check("rd_size_end",   32'(size_end), 1);
        check("rd_dv",         32'(dv_start), 0);
        wait_resp();
        check("rd_err",   32'(r_err), 0);
        check("rd_rdata", r_data, 32'h0000_3412);

        // Address NACK: master gives up after 9 rises
        issue(1'b0, 7'h48, 8'h05, 2'd0, 24'h0);
        run_phase(9, 1'b0, 32'h0, 1'b1);
        wait_resp();
        check("nack_err",   32'(r_err), 1);
        check("nack_rdata", r_data, 0);
        cnt = 0;
        for (int unsigned i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_start) cnt++;
        end
        check("nack_no_read_phase", cnt, 0);

        // Illegal write length
        @(negedge clk);
        req_write = 1'b1; req_dev = 7'h48; req_reg = 8'h02; req_len = 2'd3;
        req_valid = 1'b1;
        cnt = 0; lat = 0; seen = 1'b0; ill_err = 1'b0;
        for (int unsigned k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (m_start) cnt++;
            if (!seen && resp_valid) begin seen = 1'b1; lat = k; ill_err = resp_err; end
        end
        check("illegal_resp_in_3", 32'(seen && lat >= 1 && lat <= 3), 1);
        check("illegal_err",       32'(ill_err), 1);
        check("illegal_no_start",  cnt, 0);

        // Reset during the second data byte of a 3-byte write
        issue(1'b1, 7'h50, 8'h02, 2'd2, 24'h332211);
        run_phase(31, 1'b0, 32'h0, 1'b0);
        check("abort_size", 32'(size_start), 3);
        rst = 1'b1; m_busy = 1'b0; scl_i = 1'b0;
        @(negedge clk);
        check("abort_start", 32'(m_start), 0);
        check("abort_ready", 32'(req_ready), 1);
        check("abort_dv",    32'(m_data_valid), 0);
        check("abort_rdata", resp_rdata, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Following request completes normally: read dev 0x21 reg 0x10, 1 byte
        issue(1'b0, 7'h21, 8'h10, 2'd0, 24'h0);
        run_phase(18, 1'b0, 32'h0, 1'b1);
        check("post_ptr_byte0", 32'(cap[0]), 32'h42);
        check("post_ptr_byte1", 32'(cap[1]), 32'h10);
        run_phase(18, 1'b1, 32'h0000_00A5, 1'b1);
        check("post_rd_byte0", 32'(cap[0]), 32'h43);
        wait_resp();
        check("post_err",   32'(r_err), 0);
        check("post_rdata", r_data, 32'h0000_00A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
